// File: rtl/onewire_master.sv
// onewire_master: 1-Wire byte master. Reset op takes (T_RSTL+T_RSTH)*US_TICKS+2 cycles and byte op 8*T_SLOT*US_TICKS+2 cycles.
// One command in flight, cmd_ready only in IDLE. Defining ONEWIRE_CRC8_EN adds a Dallas CRC-8 over read bits.
module onewire_master #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int T_RSTL   = 480,
    parameter int T_PDS    = 70,
    parameter int T_RSTH   = 410,
    parameter int T_LOW1   = 6,
    parameter int T_LOW0   = 60,
    parameter int T_RDS    = 15,
    parameter int T_SLOT   = 70
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_presence,
    output logic       busy,
    output logic       dq_oe,
    input  logic       dq_in,
    output logic [7:0] crc_value
);
    localparam int US_TICKS = CLK_FREQ / 1_000_000;
    localparam int PW       = ($clog2(US_TICKS) < 1) ? 1 : $clog2(US_TICKS);
    localparam int TW       = 16;

    localparam logic [PW-1:0] PRE_END  = PW'(US_TICKS - 1);
    localparam logic [TW-1:0] RSTL_END = TW'(T_RSTL - 1);
    localparam logic [TW-1:0] PDS_AT   = TW'(T_PDS);
    localparam logic [TW-1:0] RSTH_END = TW'(T_RSTH - 1);
    localparam logic [TW-1:0] LOW1_END = TW'(T_LOW1 - 1);
    localparam logic [TW-1:0] LOW0_END = TW'(T_LOW0 - 1);
    localparam logic [TW-1:0] RDS_AT   = TW'(T_RDS);
    localparam logic [TW-1:0] SLOT_END = TW'(T_SLOT - 1);

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RST_LOW  = 3'd1;
    localparam logic [2:0] S_RST_REL  = 3'd2;
    localparam logic [2:0] S_SLOT_LOW = 3'd3;
    localparam logic [2:0] S_SLOT_REL = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] t_us_q, t_us_d;
    logic [1:0]    op_q, op_d;
    logic [7:0]    sh_q, sh_d;
    logic [2:0]    bit_q, bit_d;
    logic          pres_q, pres_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          rsp_pres_q, rsp_pres_d;
    logic          dq_m_q, dq_s_q;
    logic          us_tick;
    logic          accept;
    logic          rd_sample;
    logic [TW-1:0] low_end;

    assign us_tick   = (pre_q == PRE_END);
    // The response cycle is spent in IDLE, so ready is masked until it has gone.
    assign cmd_ready = (state_q == S_IDLE) && !rsp_valid_q;
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign rd_sample = (state_q == S_SLOT_REL) && (op_q == OP_READ) &&
                       (pre_q == '0) && (t_us_q == RDS_AT);
    assign low_end   = ((op_q == OP_WRITE) && !sh_q[0]) ? LOW0_END : LOW1_END;

    assign dq_oe        = (state_q == S_RST_LOW) || (state_q == S_SLOT_LOW);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_presence = rsp_pres_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sh_d        = sh_q;
        bit_d       = bit_q;
        pres_d      = pres_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_pres_d  = rsp_pres_q;
        pre_d       = us_tick ? '0 : pre_q + PW'(1);
        t_us_d      = us_tick ? t_us_q + TW'(1) : t_us_q;

        case (state_q)
            S_IDLE: begin
                pre_d  = '0;
                t_us_d = '0;
                if (accept) begin
                    op_d   = cmd_op;
                    sh_d   = cmd_data;
                    bit_d  = 3'd0;
                    pres_d = 1'b0;
                    case (cmd_op)
                        OP_RESET:          state_d = S_RST_LOW;
                        OP_WRITE, OP_READ: state_d = S_SLOT_LOW;
                        default:           state_d = S_DONE;
                    endcase
                end
            end
            S_RST_LOW: begin
                if (us_tick && (t_us_q == RSTL_END)) begin
                    state_d = S_RST_REL;
                    pre_d   = '0;
                    t_us_d  = '0;
                end
            end
            S_RST_REL: begin
                if ((pre_q == '0) && (t_us_q == PDS_AT)) begin
                    pres_d = ~dq_s_q;
                end
                if (us_tick && (t_us_q == RSTH_END)) begin
                    state_d = S_DONE;
                end
            end
            // The µs counter runs on through SLOT_REL so sample and slot end are measured from slot start.
            S_SLOT_LOW: begin
                if (us_tick && (t_us_q == low_end)) begin
                    state_d = S_SLOT_REL;
                end
            end
            S_SLOT_REL: begin
                if (rd_sample) begin
                    sh_d = {dq_s_q, sh_q[7:1]};
                end
                if (us_tick && (t_us_q == SLOT_END)) begin
                    // Writes rotate, so after eight slots the register holds the original byte for the echo.
                    if (op_q == OP_WRITE) begin
                        sh_d = {sh_q[0], sh_q[7:1]};
                    end
                    if (bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        state_d = S_SLOT_LOW;
                        pre_d   = '0;
                        t_us_d  = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d     = S_IDLE;
                pre_d       = '0;
                t_us_d      = '0;
                rsp_valid_d = 1'b1;
                rsp_data_d  = ((op_q == OP_WRITE) || (op_q == OP_READ)) ? sh_q : 8'h00;
                rsp_pres_d  = (op_q == OP_RESET) && pres_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pre_q       <= '0;
            t_us_q      <= '0;
            op_q        <= 2'b00;
            sh_q        <= 8'h00;
            bit_q       <= 3'd0;
            pres_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_pres_q  <= 1'b0;
            dq_m_q      <= 1'b1;
            dq_s_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            t_us_q      <= t_us_d;
            op_q        <= op_d;
            sh_q        <= sh_d;
            bit_q       <= bit_d;
            pres_q      <= pres_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_pres_q  <= rsp_pres_d;
            dq_m_q      <= dq_in;
            dq_s_q      <= dq_m_q;
        end
    end

`ifdef ONEWIRE_CRC8_EN
    // Reflected x^8+x^5+x^4+1, one bit per read sample.
    logic [7:0] crc_q, crc_d;
    logic       crc_fb;

    assign crc_fb = crc_q[0] ^ dq_s_q;

    always_comb begin
        crc_d = crc_q;
        if (accept && (cmd_op == OP_RESET)) begin
            crc_d = 8'h00;
        end else if (rd_sample) begin
            crc_d = {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_value = crc_q;
`else
    assign crc_value = 8'h00;
`endif

endmodule
